alu_sekwencer_wielobajtowy: RTL

Multi-byte arithmetic sequencer that sits directly in front of the 8-bit ALU, both driving its operand and opcode inputs and consuming its result, carry and overflow outputs. It accepts one wide operation (LICZBA_BAJTOW bytes) over a valid/ready handshake and issues it to the ALU one byte per cycle, LSB first, chaining carry/borrow through ADDC/SUBC. The block assembles the wide result and wide flags, then holds them until the consumer (register file / flag register) accepts.

---
 rtl/alu_sekwencer_wielobajtowy_pkg.sv | 51 +++++
 rtl/alu_sekwencer_wielobajtowy.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_sekwencer_wielobajtowy_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: 8-bit ALU opcodes,
// the wide command encoding and the sequencer FSM states.
package pakiet_alu;

  // 8-bit ALU opcodes
  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_INK  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ADDC = 4'b1000;
  localparam logic [3:0] OP_SUBC = 4'b1001;

  // Wide command accepted on the start handshake
  typedef enum logic [1:0] {
    CMD_ADD = 2'b00,
    CMD_SUB = 2'b01,
    CMD_AND = 2'b10,
    CMD_XOR = 2'b11
  } cmd_e;

  // Sequencer states
  typedef enum logic [1:0] {
    BEZCZYNNY = 2'b00,
    WYKONAJ   = 2'b01,
    GOTOWE    = 2'b10
  } stan_e;

  // Arithmetic commands chain carry/borrow between bytes; logic ones do not.
  function automatic logic czy_arytm(input cmd_e k);
    return (k == CMD_ADD) || (k == CMD_SUB);
  endfunction

  // Byte opcode: the first byte starts the chain, later bytes consume the carry.
  function automatic logic [3:0] kod_operacji(input cmd_e k, input logic pierwszy);
    logic [3:0] kod;
    kod = OP_LD;
    case (k)
      CMD_ADD: kod = pierwszy ? OP_ADD : OP_ADDC;
      CMD_SUB: kod = pierwszy ? OP_SUB : OP_SUBC;
      CMD_AND: kod = OP_AND;
      CMD_XOR: kod = OP_XOR;
      default: kod = OP_LD;
    endcase
    return kod;
  endfunction

endpackage

// File: rtl/alu_sekwencer_wielobajtowy.sv
// Multi-byte arithmetic sequencer: feeds a wide operation to an external
// 8-bit ALU one byte per cycle (LSB first), chains carry/borrow, and holds the
// assembled wide result and flags until the consumer accepts them.
module alu_sekwencer_wielobajtowy
  import pakiet_alu::*;
#(
  parameter int ROZM_DANYCH   = 8,
  parameter int LICZBA_BAJTOW = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_valid,
  output logic                                 start_ready,
  input  logic [1:0]                           cmd,
  input  logic [ROZM_DANYCH*LICZBA_BAJTOW-1:0] op_a,
  input  logic [ROZM_DANYCH*LICZBA_BAJTOW-1:0] op_b,
  output logic                                 wynik_valid,
  input  logic                                 wynik_ready,
  output logic [ROZM_DANYCH*LICZBA_BAJTOW-1:0] wynik,
  output logic                                 flaga_c,
  output logic                                 flaga_z,
  output logic                                 flaga_s,
  output logic                                 flaga_ov,
  output logic [ROZM_DANYCH-1:0]               alu_a,
  output logic [ROZM_DANYCH-1:0]               alu_b,
  output logic [3:0]                           alu_op,
  output logic                                 alu_c_in,
  input  logic [ROZM_DANYCH-1:0]               alu_out,
  input  logic                                 alu_c,
  input  logic                                 alu_ov
);

  localparam int W  = ROZM_DANYCH * LICZBA_BAJTOW;
  localparam int IW = (LICZBA_BAJTOW > 1) ? $clog2(LICZBA_BAJTOW) : 1;
  localparam logic [IW-1:0] OSTATNI_IDX = IW'(LICZBA_BAJTOW - 1);

  stan_e                  stan_q, stan_d;
  cmd_e                   cmd_q;
  logic [W-1:0]           a_q, b_q;
  logic [IW-1:0]          idx_q;
  logic                   zero_q;
  logic                   carry_q;
  logic                   ov_q;
  logic [ROZM_DANYCH-1:0] wynik_bajty_q [LICZBA_BAJTOW];

  logic [ROZM_DANYCH-1:0] a_bajty [LICZBA_BAJTOW];
  logic [ROZM_DANYCH-1:0] b_bajty [LICZBA_BAJTOW];
  logic [W-1:0]           wynik_pak;
  logic                   ostatni;
  logic                   gotowe;

  // Split latched operands into bytes and pack the assembled result bytes
  genvar gi;
  generate
    for (gi = 0; gi < LICZBA_BAJTOW; gi++) begin : g_bajty
      assign a_bajty[gi] = a_q[gi*ROZM_DANYCH +: ROZM_DANYCH];
      assign b_bajty[gi] = b_q[gi*ROZM_DANYCH +: ROZM_DANYCH];
      assign wynik_pak[gi*ROZM_DANYCH +: ROZM_DANYCH] = wynik_bajty_q[gi];
    end
  endgenerate

  assign ostatni = (idx_q == OSTATNI_IDX);
  assign gotowe  = (stan_q == GOTOWE);

  // Result and flags are only presented while held; otherwise they read as zero
  // so a reset mid-operation never exposes a partial result.
  assign wynik    = gotowe ? wynik_pak : '0;
  assign flaga_c  = gotowe && czy_arytm(cmd_q) && carry_q;
  assign flaga_z  = gotowe && zero_q;
  assign flaga_s  = gotowe && wynik_pak[W-1];
  assign flaga_ov = gotowe && czy_arytm(cmd_q) && ov_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stan_q <= BEZCZYNNY;
    end else begin
      stan_q <= stan_d;
    end
  end

  // Next-state logic plus handshake and ALU drive
  always_comb begin
    stan_d      = stan_q;
    start_ready = 1'b0;
    wynik_valid = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = OP_LD;
    alu_c_in    = 1'b0;
    case (stan_q)
      BEZCZYNNY: begin
        start_ready = 1'b1;
        if (start_valid) begin
          stan_d = WYKONAJ;
        end
      end
      WYKONAJ: begin
        alu_a    = a_bajty[idx_q];
        alu_b    = b_bajty[idx_q];
        alu_op   = kod_operacji(cmd_q, idx_q == '0);
        // Carry from the previous byte only matters for chained arithmetic
        alu_c_in = czy_arytm(cmd_q) && (idx_q != '0) && carry_q;
        if (ostatni) begin
          stan_d = GOTOWE;
        end
      end
      GOTOWE: begin
        wynik_valid = 1'b1;
        if (wynik_ready) begin
          stan_d = BEZCZYNNY;
        end
      end
      default: stan_d = BEZCZYNNY;
    endcase
  end

  // Operand latch and per-byte capture of ALU result, carry, overflow and zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= CMD_ADD;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      for (int j = 0; j < LICZBA_BAJTOW; j++) begin
        wynik_bajty_q[j] <= '0;
      end
    end else begin
      case (stan_q)
        BEZCZYNNY: begin
          if (start_valid) begin
            cmd_q   <= cmd_e'(cmd);
            a_q     <= op_a;
            b_q     <= op_b;
            idx_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
          end
        end
        WYKONAJ: begin
          wynik_bajty_q[idx_q] <= alu_out;
          carry_q <= alu_c;
          ov_q    <= alu_ov;
          zero_q  <= zero_q && (alu_out == '0);
          if (!ostatni) begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
